// File: rtl/bsg_channel_widen.sv
`default_nettype none
// ============================================================================
// Module   : bsg_channel_widen
// Purpose  : Assembles ratio_p narrow valid/ready words into one wide
//            valid/yumi word, first word in the least-significant slice.
// Revision : 1.0 - initial release
// ============================================================================
module bsg_channel_widen #(
    parameter int width_in_p = 8,
    parameter int ratio_p    = 2
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [width_in_p-1:0]         data_i,
    input  logic                          v_i,
    output logic                          ready_o,
    output logic [width_in_p*ratio_p-1:0] data_o,
    output logic                          v_o,
    input  logic                          yumi_i
);

    localparam int c_width_out = width_in_p * ratio_p;
    localparam int c_cnt_w     = (ratio_p > 1) ? $clog2(ratio_p) : 1;

    logic                   r_full;
    logic [c_width_out-1:0] r_data;
    logic [c_cnt_w-1:0]     w_count;
    logic                   w_last;
    logic                   w_accept;

    // yumi_i feeds ready_o combinationally so a full buffer can refill in the
    // same cycle it drains.
    assign ready_o  = ~r_full | yumi_i;
    assign w_accept = v_i & ready_o;
    assign v_o      = r_full;
    assign data_o   = r_data;

    generate
        if (ratio_p == 1) begin : g_single
            assign w_count = '0;
            assign w_last  = 1'b1;
        end else begin : g_multi
            logic [c_cnt_w-1:0] r_count;

            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    r_count <= '0;
                end else if (w_accept) begin
                    if (w_last) begin
                        r_count <= '0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
            end

            assign w_count = r_count;
            assign w_last  = (r_count == c_cnt_w'(ratio_p - 1));
        end
    endgenerate

    // Completing a word wins over a same-cycle yumi so the new word stays valid.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_full <= 1'b0;
        end else if (w_accept && w_last) begin
            r_full <= 1'b1;
        end else if (yumi_i) begin
            r_full <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < ratio_p; gi++) begin : g_slice
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    r_data[gi*width_in_p +: width_in_p] <= '0;
                end else if (w_accept && (w_count == c_cnt_w'(gi))) begin
                    r_data[gi*width_in_p +: width_in_p] <= data_i;
                end
            end
        end
    endgenerate

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(yumi_i && !r_full))
                else $error("bsg_channel_widen: yumi_i asserted while v_o is low");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_channel_widen.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_channel_widen
// Purpose  : Self-checking bench: directed vector table, 4:1 nibble case and
//            a randomized 16->8->16 round trip against a reference queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_channel_widen;

    logic        clk;
    logic        reset_i;

    logic [7:0]  a_data_i;
    logic        a_v_i;
    logic        a_ready_o;
    logic [15:0] a_data_o;
    logic        a_v_o;
    logic        a_yumi_i;

    logic [3:0]  b_data_i;
    logic        b_v_i;
    logic        b_ready_o;
    logic [15:0] b_data_o;
    logic        b_v_o;
    logic        b_yumi_i;

    int vectors    = 0;
    int miscompares = 0;

    bsg_channel_widen #(.width_in_p(8), .ratio_p(2)) u_dut_a (
        .clk_i   (clk),
        .reset_i (reset_i),
        .data_i  (a_data_i),
        .v_i     (a_v_i),
        .ready_o (a_ready_o),
        .data_o  (a_data_o),
        .v_o     (a_v_o),
        .yumi_i  (a_yumi_i)
    );

    bsg_channel_widen #(.width_in_p(4), .ratio_p(4)) u_dut_b (
        .clk_i   (clk),
        .reset_i (reset_i),
        .data_i  (b_data_i),
        .v_i     (b_v_i),
        .ready_o (b_ready_o),
        .data_o  (b_data_o),
        .v_o     (b_v_o),
        .yumi_i  (b_yumi_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst;
        logic        v;
        logic [7:0]  d;
        logic        y;
        logic        er;
        logic        ev;
        logic [15:0] ed;
    } vec_t;

    localparam int c_nvec = 23;
    vec_t tbl [c_nvec];

    logic [15:0] q_exp [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_i  = 1'b1;
        a_v_i    = 1'b0;
        a_yumi_i = 1'b0;
        b_v_i    = 1'b0;
        b_yumi_i = 1'b0;
        @(negedge clk);
        reset_i  = 1'b0;
    endtask

    initial begin
        logic [15:0] cur;
        logic [15:0] exp_w;
        logic        have;
        logic        byte_idx;
        logic        m_full;
        logic        exp_ready;
        logic        acc;
        int          sent;
        int          got;
        int          k;

        reset_i  = 1'b1;
        a_data_i = '0;
        a_v_i    = 1'b0;
        a_yumi_i = 1'b0;
        b_data_i = '0;
        b_v_i    = 1'b0;
        b_yumi_i = 1'b0;
        repeat (2) @(negedge clk);
        reset_i = 1'b0;

        // rst, v, d, yumi | ready, v_o, data_o (outputs seen before this row's edge)
        tbl[0]  = '{1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[1]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 16'h0034};
        tbl[2]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 16'h1234};
        tbl[3]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 16'h1234};
        tbl[4]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 16'h1234};
        tbl[5]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 16'h1234};
        tbl[6]  = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1, 16'h1234};
        tbl[7]  = '{1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 16'h1234};
        tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h12FF};
        tbl[9]  = '{1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[10] = '{1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 16'h0001};
        tbl[11] = '{1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 1'b1, 16'h0201};
        tbl[12] = '{1'b0, 1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 16'h0203};
        tbl[13] = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 16'h0403};
        tbl[14] = '{1'b0, 1'b1, 8'h06, 1'b0, 1'b1, 1'b0, 16'h0405};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0605};
        tbl[16] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 16'h0605};
        tbl[17] = '{1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 16'h06AA};
        tbl[18] = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 16'h0000};
        tbl[19] = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 16'h0011};
        tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h2211};
        tbl[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h2211};
        tbl[22] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h2211};

        for (int i = 0; i < c_nvec; i++) begin
            @(negedge clk);
            reset_i  = tbl[i].rst;
            a_v_i    = tbl[i].v;
            a_data_i = tbl[i].d;
            a_yumi_i = tbl[i].y;
            #1;
            check($sformatf("vec%0d_ready", i), 32'(a_ready_o), 32'(tbl[i].er));
            check($sformatf("vec%0d_v", i),     32'(a_v_o),     32'(tbl[i].ev));
            check($sformatf("vec%0d_data", i),  32'(a_data_o),  32'(tbl[i].ed));
        end

        // 4:1 nibble widening with yumi tied to v_o
        do_reset();
        q_exp.push_back(16'h4321);
        q_exp.push_back(16'h8765);
        k   = 0;
        got = 0;
        for (int cyc = 0; cyc < 20 && got < 2; cyc++) begin
            @(negedge clk);
            b_v_i    = (k < 8);
            b_data_i = 4'(k + 1);
            b_yumi_i = b_v_o;
            #1;
            check("b_ready", 32'(b_ready_o), 32'd1);
            if (b_v_o) begin
                exp_w = q_exp.pop_front();
                check("b_data", 32'(b_data_o), 32'(exp_w));
                got++;
            end
            if (b_v_i) k++;
        end
        if (got != 2) begin
            miscompares++;
            $display("FAIL b_timeout: got %0d words, expected 2", got);
        end
        @(negedge clk);
        b_v_i    = 1'b0;
        b_yumi_i = 1'b0;
        q_exp.delete();

        // 16->8->16 round trip with random gaps and yumi stalls
        do_reset();
        have     = 1'b0;
        byte_idx = 1'b0;
        m_full   = 1'b0;
        sent     = 0;
        got      = 0;
        cur      = '0;
        for (int cyc = 0; cyc < 3000 && (sent < 40 || got < 40); cyc++) begin
            @(negedge clk);
            if (!have && sent < 40) begin
                cur  = 16'($urandom);
                have = 1'b1;
                q_exp.push_back(cur);
            end
            a_v_i    = have && ($urandom_range(0, 3) != 0);
            a_data_i = byte_idx ? cur[15:8] : cur[7:0];
            a_yumi_i = m_full && ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = !m_full || a_yumi_i;
            check("rt_ready", 32'(a_ready_o), 32'(exp_ready));
            check("rt_v",     32'(a_v_o),     32'(m_full));
            if (a_yumi_i) begin
                if (q_exp.size() == 0) begin
                    miscompares++;
                    $display("FAIL rt_underflow: got output word %h, expected none", a_data_o);
                end else begin
                    exp_w = q_exp.pop_front();
                    check("rt_data", 32'(a_data_o), 32'(exp_w));
                end
                got++;
            end
            acc = a_v_i && exp_ready;
            if (acc && byte_idx) begin
                m_full = 1'b1;
            end else if (a_yumi_i) begin
                m_full = 1'b0;
            end
            if (acc) begin
                if (byte_idx) begin
                    have = 1'b0;
                    sent++;
                end
                byte_idx = ~byte_idx;
            end
        end
        if (got != 40) begin
            miscompares++;
            $display("FAIL rt_timeout: got %0d words, expected 40", got);
        end

        @(negedge clk);
        a_v_i    = 1'b0;
        a_yumi_i = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bsg_channel_widen.md
Name: bsg_channel_widen

Overview:
- Narrow-to-wide channel assembler; inverse of the team's wide-to-narrow channel narrower.
- Accepts ratio_p consecutive width_in_p-bit words over a valid/ready input and presents them as one width_in_p*ratio_p-bit word on a valid/yumi output.
- Sits on the receive side of a narrowed link, restoring the original wide word.
- Word order matches the narrower: the first word accepted lands in the least-significant slice.

Parameters:
- width_in_p, 8: width of each narrow input word in bits; must be >= 1.
- ratio_p, 2: number of narrow words per wide word; must be >= 1. Counter width is max(1, clog2(ratio_p)).

Ports:
- clk_i  input  1  single clock; all state updates on posedge.
- reset_i  input  1  synchronous, active-high reset, sampled on posedge clk_i.
- data_i  input  width_in_p  narrow input word.
- v_i  input  1  data_i valid.
- ready_o  output  1  block can accept data_i this cycle.
- data_o  output  width_in_p*ratio_p  assembled wide word.
- v_o  output  1  data_o holds a complete wide word.
- yumi_i  input  1  consumer takes data_o this cycle; legal only when v_o=1.

Behaviour:
- State: count_r (0..ratio_p-1), full_r (1 bit), data_r (width_in_p*ratio_p bits).
- Reset (reset_i=1 at posedge): count_r=0, full_r=0, data_r=0. After reset, v_o=0, ready_o=1, data_o=0. Reset has priority over every other event. A partially assembled word is discarded when reset arrives mid-assembly.
- Outputs: v_o=full_r, data_o=data_r, ready_o = ~full_r | yumi_i. The yumi_i-to-ready_o path is combinational, by design.
- Input accept: accept = v_i & ready_o. On accept, data_r[count_r*width_in_p +: width_in_p] <= data_i. Other slices hold.
- Counter:
  - On accept with count_r < ratio_p-1: count_r increments.
  - On accept with count_r == ratio_p-1: count_r wraps to 0 and full_r <= 1.
- Latency: v_o asserts the cycle after the ratio_p-th word is accepted.
- Output handshake: yumi_i=1 with full_r=1 clears full_r at the posedge unless the same cycle completes a new word. In that case full_r stays 1 and data_r holds the new word.
- Simultaneous yumi_i and accept (ratio_p>1): the accepted word writes slice 0 of the next word; full_r <= 0.
- Throughput: sustained one narrow word per cycle yields one wide word every ratio_p cycles, with no bubbles.
- Backpressure: while full_r=1 and yumi_i=0, ready_o=0. v_i is ignored, data_i is not written, count_r holds (always 0 here).
- data_o is stable while v_o=1 and yumi_i=0.
- ratio_p=1: the block degenerates to a one-entry valid/ready buffer with the same rules.
- yumi_i=1 while v_o=0 is illegal. The RTL asserts on it in simulation, and the state is unaffected.
- v_i=0: no state change except the yumi-driven clear.

Test Plan:
- width_in_p=8, ratio_p=2. After reset, present 0x34 then 0x12 with v_i=1 on consecutive cycles, yumi_i=0 -> v_o=1 the cycle after 0x12 is accepted, data_o=0x1234, ready_o=0 while yumi_i=0.
- Backpressure: with v_o=1, hold yumi_i=0 for 5 cycles while driving v_i=1, data_i=0xFF -> data_o stays 0x1234, count_r stays 0. Then pulse yumi_i=1 -> ready_o=1 that cycle, 0xFF accepted into slice 0.
- Back-to-back: stream 0x01,0x02,0x03,0x04,0x05,0x06 with yumi_i tied to v_o -> wide words 0x0201, 0x0403, 0x0605 on consecutive even cycles, no dropped or duplicated words.
- Reset mid-assembly: accept 0xAA, assert reset_i one cycle, then send 0x11,0x22 -> data_o=0x2211, and 0xAA never appears.
- ratio_p=4, width_in_p=4: send nibbles 0x1,0x2,0x3,0x4 then 0x5..0x8 -> data_o=0x4321 then 0x8765, confirming count wrap.
- Round trip: bsg_channel_narrow (16 to 8) feeding this block (8 to 16) with random 16-bit words and random yumi_i stalls -> output sequence equals input sequence.
